// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction-fetch unit.
// Holds the word-addressed program counter, drives the instruction-memory
// address, picks the next PC from stall / halt / jump / branch / sequential,
// stops fetching on the halt opcode, and keeps saturating cycle and
// retired-instruction counters for debug.
//
// Control handshake: there is no valid/ready pair here. Control inputs
// (stall, branch_taken, jump, offset, jump_target) are sampled on every
// rising edge in RUN. stall=1 freezes the PC and suppresses retirement for
// that edge. instru is the combinational read of the memory at direinstru.
// Once HALT is entered, every control input is ignored until reset.
module unidad_busqueda #(
    parameter int              AW       = 6,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [5:0]      HALT_OP  = 6'b111111,
    parameter int              CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic          jump,
    input  logic [15:0]   offset,
    input  logic [25:0]   jump_target,
    input  logic [31:0]   instru,
    output logic [AW-1:0] direinstru,
    output logic [AW-1:0] pc_mas1,
    output logic          halted,
    output logic [CW-1:0] ciclos,
    output logic [CW-1:0] retiradas
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_seq;
    logic [AW-1:0] w_pc_branch;
    logic [AW-1:0] w_pc_jump;
    logic [31:0]   w_off_ext;
    logic [AW-1:0] w_off_aw;
    logic          w_halt_op;

    logic [CW-1:0] r_ciclos;
    logic [CW-1:0] r_retiradas;
    logic          w_ciclos_inc;
    logic          w_ret_inc;

    // Candidate next-PC values; all arithmetic wraps modulo 2^AW.
    assign w_halt_op   = (instru[31:26] == HALT_OP);
    assign w_off_ext   = {{16{offset[15]}}, offset};
    assign w_off_aw    = w_off_ext[AW-1:0];
    assign w_pc_seq    = r_pc + AW'(1);
    assign w_pc_branch = w_pc_seq + w_off_aw;
    assign w_pc_jump   = jump_target[AW-1:0];

    // State and PC registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next-state / next-PC selection: stall > halt > jump > branch > +1.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ciclos_inc = 1'b0;
        w_ret_inc    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ciclos_inc = 1'b1;
                if (!stall) begin
                    w_ret_inc = 1'b1;
                    if (w_halt_op) begin
                        // PC stays on the halt instruction.
                        w_state_nxt = ST_HALT;
                    end else if (jump) begin
                        w_pc_nxt = w_pc_jump;
                    end else if (branch_taken) begin
                        w_pc_nxt = w_pc_branch;
                    end else begin
                        w_pc_nxt = w_pc_seq;
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Saturating debug counters; they freeze at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ciclos    <= '0;
            r_retiradas <= '0;
        end else begin
            if (w_ciclos_inc && !(&r_ciclos)) begin
                r_ciclos <= r_ciclos + CW'(1);
            end
            if (w_ret_inc && !(&r_retiradas)) begin
                r_retiradas <= r_retiradas + CW'(1);
            end
        end
    end

    assign direinstru = r_pc;
    assign pc_mas1    = w_pc_seq;
    assign halted     = (r_state == ST_HALT);
    assign ciclos     = r_ciclos;
    assign retiradas  = r_retiradas;

endmodule

// File: tb/tb_unidad_busqueda.sv
// Bench for unidad_busqueda: table of single-edge next-PC vectors plus
// hand-written sequences for reset, stall, halt and counter saturation.
module tb_unidad_busqueda;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [15:0] offset;
    logic [25:0] jump_target;
    logic [31:0] instru;

    logic [5:0]  direinstru;
    logic [5:0]  pc_mas1;
    logic        halted;
    logic [15:0] ciclos;
    logic [15:0] retiradas;

    logic [5:0]  s_direinstru;
    logic [5:0]  s_pc_mas1;
    logic        s_halted;
    logic [3:0]  s_ciclos;
    logic [3:0]  s_retiradas;

    int n_tests;
    int n_fail;

    unidad_busqueda dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .jump(jump), .offset(offset), .jump_target(jump_target), .instru(instru),
        .direinstru(direinstru), .pc_mas1(pc_mas1), .halted(halted),
        .ciclos(ciclos), .retiradas(retiradas)
    );

    unidad_busqueda #(.CW(4)) dut_s (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .jump(jump), .offset(offset), .jump_target(jump_target), .instru(instru),
        .direinstru(s_direinstru), .pc_mas1(s_pc_mas1), .halted(s_halted),
        .ciclos(s_ciclos), .retiradas(s_retiradas)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  start_pc;
        logic        stall;
        logic        br;
        logic        jmp;
        logic [15:0] off;
        logic [25:0] tgt;
        logic [5:0]  exp_pc;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [5:0] sp, input logic st, input logic b,
                                input logic j, input logic [15:0] o,
                                input logic [25:0] t, input logic [5:0] e);
        vec_t v;
        v.start_pc = sp; v.stall = st; v.br = b; v.jmp = j;
        v.off = o; v.tgt = t; v.exp_pc = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        offset = 16'h0; jump_target = 26'h0; instru = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_pc(input logic [5:0] p);
        idle_inputs();
        jump = 1'b1;
        jump_target = {20'h0, p};
        tick();
        jump = 1'b0;
    endtask

    logic [5:0] exp_p1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        idle_inputs();

        vecs[0]  = mk(6'd5,  0, 1, 0, 16'hFFFD, 26'h0,       6'd3);
        vecs[1]  = mk(6'd62, 0, 1, 0, 16'h0002, 26'h0,       6'd1);
        vecs[2]  = mk(6'd63, 0, 0, 0, 16'h0000, 26'h0,       6'd0);
        vecs[3]  = mk(6'd4,  0, 1, 1, 16'h0001, 26'h0000028, 6'd40);
        vecs[4]  = mk(6'd2,  0, 1, 0, 16'hFFFD, 26'h0,       6'd0);
        vecs[5]  = mk(6'd0,  0, 1, 0, 16'hFFFE, 26'h0,       6'd63);
        vecs[6]  = mk(6'd10, 1, 0, 1, 16'h0000, 26'h5,       6'd10);
        vecs[7]  = mk(6'd10, 1, 1, 0, 16'h0007, 26'h0,       6'd10);
        vecs[8]  = mk(6'd20, 0, 1, 0, 16'h0000, 26'h0,       6'd21);
        vecs[9]  = mk(6'd30, 0, 0, 1, 16'h0000, 26'h3FFFFC1, 6'd1);
        vecs[10] = mk(6'd7,  0, 0, 0, 16'h0000, 26'h0,       6'd8);
        vecs[11] = mk(6'd33, 0, 1, 0, 16'h0040, 26'h0,       6'd34);

        // Reset state and sequential fetch.
        do_reset();
        check("reset_pc", direinstru, 0);
        check("reset_pc_mas1", pc_mas1, 1);
        check("reset_halted", halted, 0);
        check("reset_ciclos", ciclos, 0);
        check("reset_retiradas", retiradas, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("seq_pc_%0d", i), direinstru, i);
            check($sformatf("seq_pc_mas1_%0d", i), pc_mas1, i + 1);
        end
        check("seq_ciclos", ciclos, 4);
        check("seq_retiradas", retiradas, 4);

        // Table-driven next-PC vectors.
        for (int i = 0; i < 12; i++) begin
            set_pc(vecs[i].start_pc);
            check($sformatf("vec%0d_start", i), direinstru, vecs[i].start_pc);
            stall = vecs[i].stall; branch_taken = vecs[i].br; jump = vecs[i].jmp;
            offset = vecs[i].off; jump_target = vecs[i].tgt;
            tick();
            exp_p1 = vecs[i].exp_pc + 6'd1;
            check($sformatf("vec%0d_pc", i), direinstru, vecs[i].exp_pc);
            check($sformatf("vec%0d_pc_mas1", i), pc_mas1, exp_p1);
            check($sformatf("vec%0d_halted", i), halted, 0);
            idle_inputs();
        end

        // Stall with pending jump: PC holds, cycles count, no retirement.
        do_reset();
        set_pc(6'd7);
        stall = 1'b1; jump = 1'b1; jump_target = 26'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc_%0d", i), direinstru, 7);
        end
        check("stall_ciclos", ciclos, 4);
        check("stall_retiradas", retiradas, 1);
        stall = 1'b0;
        tick();
        check("stall_release_pc", direinstru, 20);
        check("stall_release_retiradas", retiradas, 2);

        // Halt wins over jump/branch; HALT ignores everything.
        do_reset();
        set_pc(6'd9);
        instru = 32'hFC000000; jump = 1'b1; jump_target = 26'd3;
        branch_taken = 1'b1; offset = 16'd5;
        tick();
        check("halt_halted", halted, 1);
        check("halt_pc", direinstru, 9);
        check("halt_ciclos", ciclos, 2);
        check("halt_retiradas", retiradas, 2);
        for (int i = 0; i < 10; i++) begin
            jump = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            offset = 16'($urandom_range(0, 65535));
            jump_target = 26'($urandom_range(0, 63));
            instru = 32'($urandom_range(0, 32'h7FFFFFFF));
            tick();
        end
        check("halted_pc", direinstru, 9);
        check("halted_still", halted, 1);
        check("halted_ciclos", ciclos, 2);
        check("halted_retiradas", retiradas, 2);

        // Reset out of HALT while stall is held.
        stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_halt_pc", direinstru, 0);
        check("rst_halt_pc_mas1", pc_mas1, 1);
        check("rst_halt_halted", halted, 0);
        check("rst_halt_ciclos", ciclos, 0);
        check("rst_halt_retiradas", retiradas, 0);

        // Halt opcode under stall is not taken until stall drops.
        idle_inputs();
        instru = 32'hFC000000; stall = 1'b1;
        tick();
        check("halt_stall_halted", halted, 0);
        check("halt_stall_pc", direinstru, 0);
        check("halt_stall_ciclos", ciclos, 1);
        check("halt_stall_retiradas", retiradas, 0);
        stall = 1'b0;
        tick();
        check("halt_rel_halted", halted, 1);
        check("halt_rel_pc", direinstru, 0);
        check("halt_rel_ciclos", ciclos, 2);
        check("halt_rel_retiradas", retiradas, 1);

        // Counter saturation on the CW=4 instance; wide instance keeps counting.
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        check("sat_ciclos", s_ciclos, 15);
        check("sat_retiradas", s_retiradas, 15);
        check("wide_ciclos", ciclos, 20);
        check("wide_retiradas", retiradas, 20);
        check("sat_pc", s_direinstru, 20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("sat_ciclos_stall", s_ciclos, 15);
        check("wide_ciclos_stall", ciclos, 23);
        check("wide_retiradas_stall", retiradas, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unidad_busqueda.md
Name: unidad_busqueda

Overview:
Instruction-fetch unit of the single-cycle processor, directly upstream of the instruction memory. Holds the program counter (word address) and drives the memory address bus direinstru. Computes the next PC from sequential, branch and jump requests issued by control. Detects a halt opcode on the returned instruction word and keeps cycle and retired-instruction counters for debug.

Parameters:
AW, 6, program-counter / instruction-memory word-address width
RESET_PC, 0, PC value loaded on reset (AW bits)
HALT_OP, 6'b111111, opcode (instru[31:26]) that stops fetch
CW, 16, width of the performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC this cycle; no retirement
branch_taken  input  1  conditional branch resolved taken (beq & zero)
jump  input  1  unconditional jump
offset  input  16  signed branch offset in words (instru[15:0])
jump_target  input  26  jump target field (instru[25:0])
instru  input  32  instruction word returned combinationally by the instruction memory for direinstru
direinstru  output  AW  current PC, address into the instruction memory
pc_mas1  output  AW  direinstru+1 mod 2^AW (link value for jal)
halted  output  1  high while in HALT state
ciclos  output  CW  cycles spent in RUN
retiradas  output  CW  instructions retired

Behaviour:
- One clock, synchronous active-high reset; the reset polarity and synchronicity are fixed.
- Reset (any cycle, including while in HALT or during stall): direinstru=RESET_PC, state=RUN, halted=0, ciclos=0, retiradas=0. pc_mas1 follows combinationally, giving RESET_PC+1.
- States:
  - RUN: normal fetch.
  - HALT: absorbing; left only by reset.
- direinstru is a register. Memory read latency is 0 (combinational memory), so instru corresponds to the current direinstru in the same cycle.
- Next-PC selection in RUN, priority highest first:
  1. stall=1: PC holds.
  2. halt detect: instru[31:26]==HALT_OP. PC holds; next state HALT.
  3. jump=1: PC <= jump_target[AW-1:0].
  4. branch_taken=1: PC <= (PC + 1 + sext(offset))[AW-1:0].
  5. Otherwise: PC <= PC+1.
- Jump and branch_taken asserted together: jump wins.
- Halt opcode present together with jump or branch: halt wins, and control inputs are ignored.
- Arithmetic is modulo 2^AW; no overflow flag. Examples: PC=63, +1 gives 0; PC=2 with offset=-3 gives 0; PC=0 with offset=-2 gives 63.
- HALT state:
  - PC frozen (still points at the halt instruction); halted=1.
  - All control inputs ignored; counters frozen.
- ciclos increments on every rising edge in RUN (stalled or not), including the edge that enters HALT.
- retiradas increments on every RUN edge with stall=0, including the halt instruction itself.
- Both counters saturate at 2^CW-1 and do not wrap.
- halted is registered: it rises on the edge that enters HALT.

Test Plan:
1. Sequential fetch: reset 1 cycle, then 4 cycles with no control and instru=0 -> direinstru 0,1,2,3,4; pc_mas1 1..5; ciclos=4, retiradas=4.
2. Branch and wrap:
   - PC=5, branch_taken=1, offset=16'hFFFD -> next PC=3.
   - PC=62, offset=2 -> next PC=1 (mod 64).
   - From PC=63 with no control -> PC=0.
3. Jump priority: PC=4, jump=1, jump_target=26'h0000028, branch_taken=1, offset=1 -> next PC=0x28 (40); branch ignored.
4. Stall: PC=7, stall=1 for 3 cycles with jump=1 -> PC stays 7; ciclos +3, retiradas +0. On release, the jump is taken.
5. Halt:
   - instru=32'hFC000000 at PC=9 -> after edge halted=1, PC=9. Then 10 cycles of jump/branch -> PC=9, counters unchanged.
   - halt opcode with stall=1 -> no halt until stall drops.
6. Reset mid-operation and saturation:
   - In HALT, or with stall=1, assert reset -> next cycle PC=RESET_PC, halted=0, counters 0.
   - Preload by running 65535+ cycles (or CW=4 build: 20 cycles) -> counters stick at all-ones.
